// File: rtl/aes_round_key_gen.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_key_gen
// Description : Sequential AES-128 key schedule. A key_load captures the
//               cipher key as round key 0 and derives round keys 1..ROUNDS,
//               one per clock. All round keys are held in a local register
//               file and served through a registered, 1-cycle read port.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               key_in/key_load - cipher key (w0 = [0:31]) and start strobe
//               busy/done       - expansion in progress / 1-cycle finish pulse
//               keys_ready      - every entry holds a key of the current load
//               rd_en/rd_round  - read request and round index (0 = cipher key)
//               rd_key/rd_valid/rd_err - registered read response
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_key_gen #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:127] key_in,
  input  logic         key_load,
  output logic         busy,
  output logic         done,
  output logic         keys_ready,
  input  logic         rd_en,
  input  logic [3:0]   rd_round,
  output logic [0:127] rd_key,
  output logic         rd_valid,
  output logic         rd_err
);

  localparam logic [3:0] c_last = 4'(ROUNDS);

  // FIPS-197 forward S-box, byte x lives at bits [8*x +: 8]
  localparam logic [0:2047] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return c_sbox[{b, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_READY  = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_d;
  logic [3:0]   r_round;
  logic [7:0]   r_rcon;
  logic [0:127] r_entry [0:ROUNDS];

  logic [0:127] w_prev;
  logic [0:31]  w_rot;
  logic [0:31]  w_sub;
  logic [0:31]  w_n0, w_n1, w_n2, w_n3;
  logic [7:0]   w_rcon_next;

  // Round function on the previous round key
  assign w_prev = r_entry[r_round - 4'd1];
  assign w_rot  = {w_prev[104:127], w_prev[96:103]};

  genvar g;
  for (g = 0; g < 4; g++) begin : g_sub
    assign w_sub[8*g +: 8] = sbox(w_rot[8*g +: 8]);
  end

  assign w_n0 = w_sub ^ {r_rcon, 24'h0} ^ w_prev[0:31];
  assign w_n1 = w_n0 ^ w_prev[32:63];
  assign w_n2 = w_n1 ^ w_prev[64:95];
  assign w_n3 = w_n2 ^ w_prev[96:127];

  // xtime: multiply by x in GF(2^8) with the AES polynomial
  assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      S_IDLE, S_READY: if (key_load) w_state_d = S_EXPAND;
      S_EXPAND:        if (r_round == c_last) w_state_d = S_READY;
      default:         w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= ROUNDS; i++) r_entry[i] <= '0;
      r_round    <= 4'd0;
      r_rcon     <= 8'h01;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_ready <= 1'b0;
      rd_key     <= '0;
      rd_valid   <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE, S_READY: begin
          if (key_load) begin
            r_entry[0] <= key_in;
            r_round    <= 4'd1;
            r_rcon     <= 8'h01;
            keys_ready <= 1'b0;
            busy       <= 1'b1;
          end
        end
        S_EXPAND: begin
          // key_load is deliberately ignored here
          r_entry[r_round] <= {w_n0, w_n1, w_n2, w_n3};
          r_rcon           <= w_rcon_next;
          r_round          <= r_round + 4'd1;
          if (r_round == c_last) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            keys_ready <= 1'b1;
          end
        end
        default: ;
      endcase

      // Read port sees pre-edge keys_ready, so a read coinciding with a
      // reload still returns the old key.
      if (rd_en) begin
        if (keys_ready && (rd_round <= c_last)) begin
          rd_key   <= r_entry[rd_round];
          rd_valid <= 1'b1;
          rd_err   <= 1'b0;
        end else begin
          rd_key   <= '0;
          rd_valid <= 1'b0;
          rd_err   <= 1'b1;
        end
      end else begin
        rd_valid <= 1'b0;
        rd_err   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_key_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_key_gen
// Description : Self-checking bench for aes_round_key_gen. Expected round keys
//               come from a FIPS-197 word-recurrence model whose S-box is
//               built from the GF(2^8) inverse and affine transform.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_key_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic [0:127] key_in;
  logic         key_load;
  logic         busy, done, keys_ready;
  logic         rd_en;
  logic [3:0]   rd_round;
  logic [0:127] rd_key;
  logic         rd_valid, rd_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [0:255];
  logic [0:127] exp_keys [0:10];

  localparam logic [0:127] c_fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] c_fips_r1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [0:127] c_fips_r10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [0:127] c_zero_r1  = 128'h62636363626363636263636362636363;
  localparam logic [0:127] c_zero_r10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_round_key_gen #(.ROUNDS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_load   (key_load),
    .busy       (busy),
    .done       (done),
    .keys_ready (keys_ready),
    .rd_en      (rd_en),
    .rd_round   (rd_round),
    .rd_key     (rd_key),
    .rd_valid   (rd_valid),
    .rd_err     (rd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic compute_model(input logic [0:127] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [0:127] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic read_round(input logic [3:0] idx);
    rd_en    = 1'b1;
    rd_round = idx;
    tick();
    rd_en    = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        cycles = i;
        break;
      end
    end
  endtask

  function automatic logic [0:127] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; key_in = '0; key_load = 1'b0; rd_en = 1'b0; rd_round = 4'd0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, keys_ready, rd_valid, rd_err} !== 5'b0 || rd_key !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b ready=%b valid=%b err=%b key=%h exp all zero",
               busy, done, keys_ready, rd_valid, rd_err, rd_key);
    end
    read_round(4'd0);
    checks++;
    if (rd_err !== 1'b1 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_read got err=%b valid=%b exp err=1 valid=0", rd_err, rd_valid);
    end
  endtask

  task automatic test_fips_load();
    logic ok;
    compute_model(c_fips_key);
    load_key(c_fips_key);
    checks++;
    if (busy !== 1'b1 || keys_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL load_edge got busy=%b ready=%b done=%b exp 1 0 0", busy, keys_ready, done);
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      ok = (k < 10) ? (busy === 1'b1 && done === 1'b0 && keys_ready === 1'b0)
                    : (busy === 1'b0 && done === 1'b1 && keys_ready === 1'b1);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL expand_timing cycle=%0d got busy=%b done=%b ready=%b", k, busy, done, keys_ready);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || keys_ready !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse got done=%b ready=%b exp done=0 ready=1", done, keys_ready);
    end
  endtask

  task automatic test_readback();
    logic [3:0]   idx [0:2];
    logic [0:127] ref_k [0:2];
    idx[0] = 4'd0;  ref_k[0] = c_fips_key;
    idx[1] = 4'd1;  ref_k[1] = c_fips_r1;
    idx[2] = 4'd10; ref_k[2] = c_fips_r10;
    for (int i = 0; i < 3; i++) begin
      read_round(idx[i]);
      checks++;
      if (rd_key !== ref_k[i] || rd_valid !== 1'b1 || rd_err !== 1'b0) begin
        errors++;
        $display("FAIL readback round=%0d got %h v=%b e=%b exp %h", idx[i], rd_key, rd_valid, rd_err, ref_k[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    rd_en = 1'b1;
    rd_round = 4'd0;
    for (int i = 0; i <= 10; i++) begin
      tick();
      checks++;
      if (rd_key !== exp_keys[i] || rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_read round=%0d got %h v=%b exp %h", i, rd_key, rd_valid, exp_keys[i]);
      end
      if (i < 10) rd_round = 4'(i + 1);
    end
    rd_en = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_key !== exp_keys[10]) begin
      errors++;
      $display("FAIL read_hold got %h v=%b e=%b exp %h v=0 e=0", rd_key, rd_valid, rd_err, exp_keys[10]);
    end
  endtask

  task automatic test_illegal();
    for (int r = 11; r <= 15; r++) begin
      read_round(4'(r));
      checks++;
      if (rd_err !== 1'b1 || rd_valid !== 1'b0 || rd_key !== '0) begin
        errors++;
        $display("FAIL out_of_range round=%0d got err=%b v=%b key=%h exp err=1 v=0 key=0", r, rd_err, rd_valid, rd_key);
      end
    end
  endtask

  task automatic test_load_during_expand();
    int cyc;
    compute_model(c_fips_key);
    load_key(c_fips_key);
    tick(); tick(); tick();
    // edge T+4: a second load plus a read, both during expansion
    key_in = rand_key(); key_load = 1'b1; rd_en = 1'b1; rd_round = 4'd0;
    tick();
    key_load = 1'b0; rd_en = 1'b0;
    checks++;
    if (rd_err !== 1'b1 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_in_expand got err=%b v=%b exp err=1 v=0", rd_err, rd_valid);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 6) begin
      errors++;
      $display("FAIL ignored_load_timing got %0d exp 6 more cycles", cyc);
    end
    read_round(4'd10);
    checks++;
    if (rd_key !== c_fips_r10) begin
      errors++;
      $display("FAIL ignored_load_key got %h exp %h", rd_key, c_fips_r10);
    end
  endtask

  task automatic test_reload_zero();
    int cyc;
    key_in = '0; key_load = 1'b1; rd_en = 1'b1; rd_round = 4'd10;
    tick();
    key_load = 1'b0; rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_key !== c_fips_r10 || keys_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reload_same_edge got key=%h v=%b ready=%b busy=%b exp %h v=1 ready=0 busy=1",
               rd_key, rd_valid, keys_ready, busy, c_fips_r10);
    end
    compute_model('0);
    wait_done(cyc);
    checks++;
    if (cyc !== 10) begin
      errors++;
      $display("FAIL reload_timing got %0d exp 10", cyc);
    end
    read_round(4'd1);
    checks++;
    if (rd_key !== c_zero_r1 || rd_key !== exp_keys[1]) begin
      errors++;
      $display("FAIL zero_round1 got %h exp %h", rd_key, c_zero_r1);
    end
    read_round(4'd10);
    checks++;
    if (rd_key !== c_zero_r10 || rd_key !== exp_keys[10]) begin
      errors++;
      $display("FAIL zero_round10 got %h exp %h", rd_key, c_zero_r10);
    end
  endtask

  task automatic test_random_keys();
    int           cyc;
    logic [0:127] k;
    logic [3:0]   r;
    for (int n = 0; n < 8; n++) begin
      k = rand_key();
      compute_model(k);
      load_key(k);
      wait_done(cyc);
      checks++;
      if (cyc !== 10) begin
        errors++;
        $display("FAIL rand_timing key=%h got %0d exp 10", k, cyc);
      end
      for (int j = 0; j < 4; j++) begin
        r = 4'($urandom_range(0, 10));
        read_round(r);
        checks++;
        if (rd_key !== exp_keys[r] || rd_valid !== 1'b1) begin
          errors++;
          $display("FAIL rand_read key=%h round=%0d got %h exp %h", k, r, rd_key, exp_keys[r]);
        end
      end
      r = 4'($urandom_range(11, 15));
      read_round(r);
      checks++;
      if (rd_err !== 1'b1 || rd_key !== '0) begin
        errors++;
        $display("FAIL rand_oor round=%0d got err=%b key=%h exp err=1 key=0", r, rd_err, rd_key);
      end
    end
  endtask

  task automatic test_rst_mid();
    logic saw_done;
    load_key(rand_key());
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || keys_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got busy=%b ready=%b done=%b exp 0 0 0", busy, keys_ready, done);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_done got done pulse exp none");
    end
    read_round(4'd0);
    checks++;
    if (rd_err !== 1'b1 || rd_valid !== 1'b0 || rd_key !== '0) begin
      errors++;
      $display("FAIL rst_read got err=%b v=%b key=%h exp err=1 v=0 key=0", rd_err, rd_valid, rd_key);
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_load();
    test_readback();
    test_back_to_back();
    test_illegal();
    test_load_during_expand();
    test_reload_zero();
    test_random_keys();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
